// File: rtl/m_beep_ctrl.sv
// m_beep_ctrl: buzzer burst sequencer sitting behind the UART frame decoder.
// Each valid command plays num pulses of a given period and high time on
// o_beep. One command can wait in a pending slot while a burst plays.
// Optional feature macro: BEEP_ABORT_EN adds an i_abort input that cancels
// the running burst and drops any pending command.
module m_beep_ctrl #(
    parameter logic        BEEP_ACTIVE = 1'b1,
    parameter logic [15:0] GAP_CYCLES  = 16'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
`ifdef BEEP_ABORT_EN
    input  logic        i_abort,
`endif
    input  logic        i_beep_en,
    input  logic [31:0] i_beep_periord,
    input  logic [31:0] i_beep_high,
    input  logic [15:0] i_beep_num,
    output logic        o_beep,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_ovf
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

    state_t      state_q;
    logic [31:0] period_q;
    logic [31:0] high_q;
    logic [31:0] cycCnt_q;
    logic [31:0] cycCnt_d;
    logic [15:0] pulseCnt_q;
    logic [15:0] gapCnt_q;
    logic        pendValid_q;
    logic [31:0] pendPeriod_q;
    logic [31:0] pendHigh_q;
    logic [15:0] pendNum_q;
    logic        beep_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        ovf_q;

    logic        abortReq;
    logic        cmdValid;
    logic        cmdBad;
    logic [31:0] cmdHigh;
    logic        cycWrap;
    logic        runLast;
    logic        gapLast;
    logic [31:0] nxtPeriod;
    logic [31:0] nxtHigh;
    logic [15:0] nxtNum;

`ifdef BEEP_ABORT_EN
    assign abortReq = i_abort;
`else
    assign abortReq = 1'b0;
`endif

    // Command qualification, counter stepping and selection of the next burst source
    // (the pending slot wins; otherwise the strobe arriving this cycle is used).
    always_comb begin
        cmdValid  = i_beep_en && !abortReq && (i_beep_periord != 32'd0) && (i_beep_num != 16'd0);
        cmdBad    = i_beep_en && !abortReq && !((i_beep_periord != 32'd0) && (i_beep_num != 16'd0));
        cmdHigh   = (i_beep_high > i_beep_periord) ? i_beep_periord : i_beep_high;
        cycWrap   = (cycCnt_q == period_q - 32'd1);
        cycCnt_d  = cycWrap ? 32'd0 : cycCnt_q + 32'd1;
        runLast   = (state_q == ST_RUN) && cycWrap && (pulseCnt_q == 16'd1);
        gapLast   = (state_q == ST_GAP) && (gapCnt_q == GAP_CYCLES - 16'd1);
        nxtPeriod = pendValid_q ? pendPeriod_q : i_beep_periord;
        nxtHigh   = pendValid_q ? pendHigh_q   : cmdHigh;
        nxtNum    = pendValid_q ? pendNum_q    : i_beep_num;
    end

    // Burst sequencer: IDLE -> RUN -> (GAP) -> IDLE/RUN, with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            period_q     <= 32'd0;
            high_q       <= 32'd0;
            cycCnt_q     <= 32'd0;
            pulseCnt_q   <= 16'd0;
            gapCnt_q     <= 16'd0;
            pendValid_q  <= 1'b0;
            pendPeriod_q <= 32'd0;
            pendHigh_q   <= 32'd0;
            pendNum_q    <= 16'd0;
            beep_q       <= ~BEEP_ACTIVE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= cmdBad;
            ovf_q  <= 1'b0;
            if (abortReq) begin
                state_q     <= ST_IDLE;
                pendValid_q <= 1'b0;
                beep_q      <= ~BEEP_ACTIVE;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmdValid) begin
                            state_q    <= ST_RUN;
                            period_q   <= nxtPeriod;
                            high_q     <= nxtHigh;
                            cycCnt_q   <= 32'd0;
                            pulseCnt_q <= nxtNum;
                            busy_q     <= 1'b1;
                            beep_q     <= (nxtHigh != 32'd0) ? BEEP_ACTIVE : ~BEEP_ACTIVE;
                        end
                    end
                    ST_RUN: begin
                        if (runLast) begin
                            done_q <= 1'b1;
                            if (pendValid_q || cmdValid) begin
                                if (GAP_CYCLES == 16'd0) begin
                                    state_q     <= ST_RUN;
                                    period_q    <= nxtPeriod;
                                    high_q      <= nxtHigh;
                                    cycCnt_q    <= 32'd0;
                                    pulseCnt_q  <= nxtNum;
                                    busy_q      <= 1'b1;
                                    beep_q      <= (nxtHigh != 32'd0) ? BEEP_ACTIVE : ~BEEP_ACTIVE;
                                    pendValid_q <= pendValid_q && cmdValid;
                                    if (pendValid_q && cmdValid) begin
                                        pendPeriod_q <= i_beep_periord;
                                        pendHigh_q   <= cmdHigh;
                                        pendNum_q    <= i_beep_num;
                                    end
                                end else begin
                                    state_q  <= ST_GAP;
                                    gapCnt_q <= 16'd0;
                                    busy_q   <= 1'b1;
                                    beep_q   <= ~BEEP_ACTIVE;
                                    if (cmdValid) begin
                                        pendValid_q  <= 1'b1;
                                        pendPeriod_q <= i_beep_periord;
                                        pendHigh_q   <= cmdHigh;
                                        pendNum_q    <= i_beep_num;
                                        ovf_q        <= pendValid_q;
                                    end
                                end
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                beep_q  <= ~BEEP_ACTIVE;
                            end
                        end else begin
                            cycCnt_q <= cycCnt_d;
                            if (cycWrap) begin
                                pulseCnt_q <= pulseCnt_q - 16'd1;
                            end
                            beep_q <= (cycCnt_d < high_q) ? BEEP_ACTIVE : ~BEEP_ACTIVE;
                            if (cmdValid) begin
                                pendValid_q  <= 1'b1;
                                pendPeriod_q <= i_beep_periord;
                                pendHigh_q   <= cmdHigh;
                                pendNum_q    <= i_beep_num;
                                ovf_q        <= pendValid_q;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gapLast) begin
                            state_q     <= ST_RUN;
                            period_q    <= nxtPeriod;
                            high_q      <= nxtHigh;
                            cycCnt_q    <= 32'd0;
                            pulseCnt_q  <= nxtNum;
                            busy_q      <= 1'b1;
                            beep_q      <= (nxtHigh != 32'd0) ? BEEP_ACTIVE : ~BEEP_ACTIVE;
                            pendValid_q <= cmdValid;
                            if (cmdValid) begin
                                pendPeriod_q <= i_beep_periord;
                                pendHigh_q   <= cmdHigh;
                                pendNum_q    <= i_beep_num;
                            end
                        end else begin
                            gapCnt_q <= gapCnt_q + 16'd1;
                            if (cmdValid) begin
                                pendValid_q  <= 1'b1;
                                pendPeriod_q <= i_beep_periord;
                                pendHigh_q   <= cmdHigh;
                                pendNum_q    <= i_beep_num;
                                ovf_q        <= pendValid_q;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        beep_q  <= ~BEEP_ACTIVE;
                    end
                endcase
            end
        end
    end

    assign o_beep = beep_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err  = err_q;
    assign o_ovf  = ovf_q;

endmodule
